// File: rtl/eth_pkg.sv
// Shared widths and transmitter state encoding for the serial frame link.
package eth_pkg;
    localparam int ETH_ADDR_W = 11;
    localparam int ETH_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LOAD,
        LOW,
        HIGH,
        FINISH
    } tx_state_t;
endpackage

// File: rtl/eth_sck_timer.sv
// Half-period timer for the serial clock: counts CLK_DIV cycles while run is
// high and strobes phase_end on the last cycle of each half-period.
module eth_sck_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic phase_end
);
    logic [7:0] cnt;

    assign phase_end = run && (cnt == 8'(CLK_DIV - 1));

    // Counter restarts whenever the phase ends or sck is parked, so every
    // LOW/HIGH phase starts from zero.
    always_ff @(posedge clk) begin
        if (rst || !run || phase_end)
            cnt <= '0;
        else
            cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/eth_transmitter.sv
// Frame transmitter: reads len bytes from a sync-read buffer and shifts them
// out LSB first on sck/mosi, framed by ena, with a done pulse at frame end.
module eth_transmitter
    import eth_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ETH_ADDR_W-1:0] len,
    output logic [ETH_ADDR_W-1:0] tx_a,
    input  logic [ETH_DATA_W-1:0] tx_d,
    output logic                  sck,
    output logic                  mosi,
    output logic                  ena,
    output logic                  busy,
    output logic                  done
);
    tx_state_t             state, state_next;
    logic [ETH_ADDR_W-1:0] len_q;
    logic [ETH_ADDR_W-1:0] byte_cnt;
    logic [ETH_DATA_W-1:0] shift;
    logic [2:0]            bit_cnt;
    logic                  phase_end;
    logic                  last_byte;

    // The address already points at the current byte, so ADDR only spends the
    // cycle the buffer needs to return data.
    assign tx_a      = byte_cnt;
    assign last_byte = (ETH_ADDR_W'(byte_cnt + 1'b1) == len_q);

    eth_sck_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       ((state == LOW) || (state == HIGH)),
        .phase_end (phase_end)
    );

    // State register; reset wins over everything, including start.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Datapath: length latch, byte/bit counters and the output shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        len_q    <= len;
                        byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    shift   <= tx_d;
                    bit_cnt <= '0;
                end
                HIGH: begin
                    if (phase_end) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and Moore outputs; mosi only moves on entry to LOW, so it is
    // never changing while sck is high.
    always_comb begin
        state_next = state;
        sck        = 1'b0;
        mosi       = 1'b0;
        ena        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = (len != '0) ? ADDR : FINISH;
            end
            ADDR: begin
                ena        = 1'b1;
                busy       = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                ena        = 1'b1;
                busy       = 1'b1;
                state_next = LOW;
            end
            LOW: begin
                ena  = 1'b1;
                busy = 1'b1;
                mosi = shift[0];
                if (phase_end)
                    state_next = HIGH;
            end
            HIGH: begin
                ena  = 1'b1;
                busy = 1'b1;
                sck  = 1'b1;
                mosi = shift[0];
                if (phase_end) begin
                    if (bit_cnt != 3'd7)
                        state_next = LOW;
                    else
                        state_next = last_byte ? FINISH : ADDR;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_eth_transmitter.sv
// Directed bench: three transmitters (CLK_DIV 2, 1, 5), each with its own
// sync-read buffer and a behavioural receiver that logs (address, byte) pairs.
module tb_eth_transmitter;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        start_i [3];
    logic [10:0] len_i   [3];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
        logic [10:0] tx_a;
        logic [7:0]  tx_d;
        logic        sck, mosi, ena, busy, done;
        logic [7:0]  mem [2048];

        eth_transmitter #(.CLK_DIV(DIV)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_i[g]),
            .len   (len_i[g]),
            .tx_a  (tx_a),
            .tx_d  (tx_d),
            .sck   (sck),
            .mosi  (mosi),
            .ena   (ena),
            .busy  (busy),
            .done  (done)
        );

        always @(posedge clk) tx_d <= mem[tx_a];

        logic        sck_q, mosi_q;
        logic [2:0]  rbit;
        logic [7:0]  rsh;
        logic [10:0] ra;
        int sck_edges, done_cnt, done_cyc, busy_cyc, ena_cyc, viol, rx_n;
        int hi_run, lo_run, hi_min, hi_max, lo_min, lo_max;
        logic [10:0] rx_a_log [2048];
        logic [7:0]  rx_d_log [2048];

        always @(negedge clk) begin
            if (clr) begin
                sck_edges <= 0; done_cnt <= 0; done_cyc <= -1; busy_cyc <= 0;
                ena_cyc <= 0; viol <= 0; rx_n <= 0;
                hi_min <= 1000; hi_max <= 0; lo_min <= 1000; lo_max <= 0;
            end else begin
                if (done === 1'b1) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
                if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
                if (ena === 1'b1) ena_cyc <= ena_cyc + 1;
                if (ena === 1'b1 && sck === 1'b1 && mosi !== mosi_q) viol <= viol + 1;
                if (sck === 1'b1 && sck_q === 1'b0) begin
                    sck_edges <= sck_edges + 1;
                    if (rbit != 3'd0) begin
                        lo_min <= (lo_run < lo_min) ? lo_run : lo_min;
                        lo_max <= (lo_run > lo_max) ? lo_run : lo_max;
                    end
                end
                if (sck_q === 1'b1 && sck === 1'b0) begin
                    hi_min <= (hi_run < hi_min) ? hi_run : hi_min;
                    hi_max <= (hi_run > hi_max) ? hi_run : hi_max;
                end
                if (ena === 1'b1 && sck === 1'b1 && sck_q === 1'b0) begin
                    rsh  <= {mosi, rsh[7:1]};
                    rbit <= rbit + 3'd1;
                    if (rbit == 3'd7) begin
                        if (rx_n < 2048) begin
                            rx_a_log[rx_n[10:0]] <= ra;
                            rx_d_log[rx_n[10:0]] <= {mosi, rsh[7:1]};
                        end
                        rx_n <= rx_n + 1;
                        ra   <= ra + 11'd1;
                    end
                end
            end
            if (ena !== 1'b1) begin rbit <= 3'd0; ra <= 11'd0; end
            hi_run <= (sck === 1'b1) ? ((sck_q === 1'b1) ? hi_run + 1 : 1) : hi_run;
            lo_run <= (sck === 1'b0) ? ((sck_q === 1'b0) ? lo_run + 1 : 1) : lo_run;
            sck_q  <= sck;
            mosi_q <= mosi;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic pulse_start(input int k, input logic [10:0] l);
        @(posedge clk);
        #1;
        start_i[k] = 1'b1;
        len_i[k]   = l;
        @(posedge clk);
        #1 start_i[k] = 1'b0;
    endtask

    logic [7:0] exp7 [7];
    logic [7:0] exp4 [4];
    logic [7:0] pat;
    int s, e;

    initial begin
        exp7 = '{8'h10, 8'hd5, 8'h20, 8'hff, 8'h00, 8'ha5, 8'h73};
        exp4 = '{8'hff, 8'h00, 8'ha5, 8'h73};
        rst = 1'b1;
        clr = 1'b1;
        for (int k = 0; k < 3; k++) begin start_i[k] = 1'b0; len_i[k] = '0; end
        for (int i = 0; i < 2048; i++) begin
            u[0].mem[i] = 8'h00; u[1].mem[i] = 8'h00; u[2].mem[i] = 8'h00;
        end
        for (int i = 0; i < 7; i++) u[0].mem[i] = exp7[i];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sck",  int'(u[0].sck),  0);
        chk("rst_mosi", int'(u[0].mosi), 0);
        chk("rst_ena",  int'(u[0].ena),  0);
        chk("rst_busy", int'(u[0].busy), 0);
        chk("rst_done", int'(u[0].done), 0);
        chk("rst_tx_a", int'(u[0].tx_a), 0);
        rst = 1'b0;
        clear();

        // Seven-byte frame at CLK_DIV=2.
        @(posedge clk);
        #1;
        start_i[0] = 1'b1; len_i[0] = 11'd7; s = cyc;
        @(posedge clk);
        #1 start_i[0] = 1'b0;
        for (int i = 0; i < 400 && u[0].done_cnt == 0; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        chk("f7_rx_n", u[0].rx_n, 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("f7_addr%0d", i), int'(u[0].rx_a_log[i]), i);
            chk($sformatf("f7_data%0d", i), int'(u[0].rx_d_log[i]), int'(exp7[i]));
        end
        chk("f7_done_cnt", u[0].done_cnt, 1);
        chk("f7_ena_cyc",  u[0].ena_cyc, 238);
        chk("f7_done_cyc", u[0].done_cyc, s + 239);
        chk("f7_mosi_hi",  u[0].viol, 0);
        chk("f7_hi_min",   u[0].hi_min, 2);
        chk("f7_hi_max",   u[0].hi_max, 2);
        chk("f7_lo_max",   u[0].lo_max, 2);

        // Zero-length request.
        clear();
        @(posedge clk);
        #1;
        start_i[0] = 1'b1; len_i[0] = 11'd0; s = cyc;
        @(posedge clk);
        #1 start_i[0] = 1'b0;
        repeat (10) @(posedge clk);
        chk("l0_done_cnt", u[0].done_cnt, 1);
        chk("l0_done_cyc", u[0].done_cyc, s + 1);
        chk("l0_busy",     u[0].busy_cyc, 0);
        chk("l0_sck",      u[0].sck_edges, 0);

        // Abort after three bytes with reset.
        clear();
        pulse_start(0, 11'd7);
        for (int i = 0; i < 500 && u[0].rx_n < 3; i++) @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("ab_sck",  int'(u[0].sck),  0);
        chk("ab_ena",  int'(u[0].ena),  0);
        chk("ab_busy", int'(u[0].busy), 0);
        e = u[0].sck_edges;
        repeat (100) @(posedge clk);
        chk("ab_edges", u[0].sck_edges, e);
        chk("ab_done",  u[0].done_cnt, 0);
        chk("ab_rx_n",  u[0].rx_n, 3);

        // Fresh four-byte frame after the abort.
        for (int i = 0; i < 4; i++) u[0].mem[i] = exp4[i];
        clear();
        pulse_start(0, 11'd4);
        for (int i = 0; i < 300 && u[0].done_cnt == 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        chk("f4_rx_n", u[0].rx_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f4_addr%0d", i), int'(u[0].rx_a_log[i]), i);
            chk($sformatf("f4_data%0d", i), int'(u[0].rx_d_log[i]), int'(exp4[i]));
        end
        chk("f4_done", u[0].done_cnt, 1);

        // Reset and start in the same cycle: reset wins.
        clear();
        @(posedge clk);
        #1;
        rst = 1'b1; start_i[0] = 1'b1; len_i[0] = 11'd5;
        @(posedge clk);
        #1;
        rst = 1'b0; start_i[0] = 1'b0;
        chk("rs_busy", int'(u[0].busy), 0);
        repeat (20) @(posedge clk);
        chk("rs_edges", u[0].sck_edges, 0);
        chk("rs_done",  u[0].done_cnt, 0);

        // Second start mid-frame is ignored.
        clear();
        pulse_start(0, 11'd3);
        repeat (50) @(posedge clk);
        pulse_start(0, 11'd5);
        for (int i = 0; i < 300 && u[0].done_cnt == 0; i++) @(posedge clk);
        repeat (200) @(posedge clk);
        chk("ms_rx_n",  u[0].rx_n, 3);
        chk("ms_done",  u[0].done_cnt, 1);
        chk("ms_ena",   u[0].ena_cyc, 102);
        chk("ms_data2", int'(u[0].rx_d_log[2]), 8'ha5);

        // CLK_DIV=1 and CLK_DIV=5 with two bytes aa,55.
        u[1].mem[0] = 8'haa; u[1].mem[1] = 8'h55;
        u[2].mem[0] = 8'haa; u[2].mem[1] = 8'h55;
        clear();
        @(posedge clk);
        #1;
        start_i[1] = 1'b1; len_i[1] = 11'd2;
        start_i[2] = 1'b1; len_i[2] = 11'd2;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0; start_i[2] = 1'b0;
        for (int i = 0; i < 400 && u[2].done_cnt == 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        chk("d1_hi_min", u[1].hi_min, 1);
        chk("d1_hi_max", u[1].hi_max, 1);
        chk("d1_lo_min", u[1].lo_min, 1);
        chk("d1_lo_max", u[1].lo_max, 1);
        chk("d1_ena",    u[1].ena_cyc, 36);
        chk("d1_rx_n",   u[1].rx_n, 2);
        chk("d1_b0",     int'(u[1].rx_d_log[0]), 8'haa);
        chk("d1_b1",     int'(u[1].rx_d_log[1]), 8'h55);
        chk("d1_a1",     int'(u[1].rx_a_log[1]), 1);
        chk("d5_hi_min", u[2].hi_min, 5);
        chk("d5_hi_max", u[2].hi_max, 5);
        chk("d5_lo_min", u[2].lo_min, 5);
        chk("d5_lo_max", u[2].lo_max, 5);
        chk("d5_ena",    u[2].ena_cyc, 164);
        chk("d5_rx_n",   u[2].rx_n, 2);
        chk("d5_b0",     int'(u[2].rx_d_log[0]), 8'haa);
        chk("d5_b1",     int'(u[2].rx_d_log[1]), 8'h55);
        chk("d5_a1",     int'(u[2].rx_a_log[1]), 1);
        chk("d5_mosi_hi", u[2].viol, 0);

        // Maximum length 2047 at CLK_DIV=1: addresses 0..2046.
        for (int i = 0; i < 2048; i++) u[1].mem[i] = 8'((i * 7) + 3);
        clear();
        pulse_start(1, 11'd2047);
        for (int i = 0; i < 40000 && u[1].done_cnt == 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        chk("mx_done", u[1].done_cnt, 1);
        chk("mx_rx_n", u[1].rx_n, 2047);
        chk("mx_ena",  u[1].ena_cyc, 2047 * 18);
        chk("mx_a2046", int'(u[1].rx_a_log[2046]), 2046);
        pat = 8'((2046 * 7) + 3);
        chk("mx_d2046", int'(u[1].rx_d_log[2046]), int'(pat));
        pat = 8'((1000 * 7) + 3);
        chk("mx_d1000", int'(u[1].rx_d_log[1000]), int'(pat));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
